lsu_mem_queue: RTL and testbench
================================

Name: lsu_mem_queue

Overview:
- Load/store issue stage directly upstream of the byte-addressed data memory in the 2-way superscalar core.
- Accepts up to two memory ops per cycle from the two MEM lanes, with lane0 older than lane1, and queues them in program order.
- Drives the memory's enable-sensitive interface one op at a time, with an enable-low gap between ops.
- Captures load data, masks it to size, sign/zero-extends it, and returns it with the destination register tag.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 4.
- XLEN, 64, address and data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  lane0 (older) memory op valid.
- req0_is_store  in  1  1 = store, 0 = load.
- req0_funct3  in  3  RISC-V funct3: LB/LH/LW/LD/LBU/LHU/LWU, or SB/SH/SW/SD.
- req0_addr  in  XLEN  effective address.
- req0_wdata  in  XLEN  store data.
- req0_rd  in  5  load destination register.
- req1_valid, req1_is_store, req1_funct3, req1_addr, req1_wdata, req1_rd  in  same widths  lane1 (younger) op.
- req_ready  out  1  both lanes may enqueue this cycle.
- mem_load_format  out  3  to data memory.
- mem_store_format  out  2  to data memory.
- mem_write_en  out  1  to data memory.
- mem_read_en  out  1  to data memory.
- mem_addr  out  XLEN  to data memory.
- mem_data_input  out  XLEN  store data to data memory.
- mem_data_output  in  XLEN  load data from data memory.
- ld_valid  out  1  one-cycle pulse: load result valid.
- ld_rd  out  5  load result tag.
- ld_data  out  XLEN  extended load result.
- busy  out  1  queue non-empty or FSM not IDLE.

Behaviour:
- Reset, asynchronous: queue flushed (count=0, pointers=0), FSM=IDLE.
  - All mem_* outputs 0; ld_valid=0, ld_rd=0, ld_data=0.
  - Reset mid-ACCESS drops both enables immediately; the in-flight op is lost and no ld_valid is produced.
- req_ready = (count <= DEPTH-2), computed from registered count. It is combinational and independent of the req valids.
- Enqueue at the rising edge when req_ready is 1:
  - lane0 is written first, then lane1.
  - If only req1_valid is set, it takes a single slot.
  - Requests presented while req_ready=0 are ignored; upstream must hold them.
- FSM states IDLE, ACCESS, RELEASE:
  - IDLE: if count!=0 at the edge, pop the head and go to ACCESS; otherwise stay.
  - ACCESS (one cycle): mem_addr, mem_data_input and the formats are driven from the popped entry.
    - Store: mem_write_en=1, mem_read_en=0.
    - Load: mem_read_en=1, mem_write_en=0.
    - Next state is always RELEASE.
    - On a load, mem_data_output is sampled at the edge that ends ACCESS.
  - RELEASE (one cycle): both enables 0; addr, data and formats hold.
    - If count!=0, pop and go to ACCESS; otherwise go to IDLE.
- Throughput is one op per 2 cycles. Enables are never high in two consecutive cycles.
- Push and pop at the same edge are both legal; count updates by pushes minus pops.
- Format mapping uses size = funct3[1:0]:
  - mem_store_format = size.
  - mem_load_format: 00→000, 01→001, 10→010, 11→101.
- Load extension at the sample edge:
  - Mask mem_data_output to 8/16/32/64 bits, because upper bytes from memory are stale.
  - If funct3[2]=0, sign-extend from the top bit of the size; if 1, zero-extend.
  - funct3 111 is treated as LD with no extension.
- Load result timing: ld_valid=1 and ld_rd/ld_data are registered in the cycle after ACCESS (the RELEASE cycle).
  - ld_valid=0 otherwise; ld_rd/ld_data hold.
- Latency: request presented in cycle 0 with an empty queue and FSM IDLE:
  - enqueue at edge 1;
  - ACCESS after edge 2;
  - ld_valid after edge 3.
- Ordering: strict program order. A store followed by a load to the same address returns the stored data; no forwarding path is needed.
- Alignment: address passed through unchecked; misalignment is the memory's concern.
- busy = (count!=0) | (state!=IDLE).

Test Plan:
- Reset: assert reset_n=0 mid-ACCESS of a load -> enables drop at once, all outputs 0, no ld_valid after release, busy=0.
- Store then load, one per cycle on lane0:
  - SD addr 0x10 data 0x8877665544332211, then LD 0x10 rd=5.
  - Expect mem_write_en high for one cycle, one low cycle, then mem_read_en high.
  - ld_valid with rd=5, data 0x8877665544332211.
- Extension, after SD 0x20 data 0x0000000080008080:
  - LB 0x20 -> 0xFFFFFFFFFFFFFF80.
  - LBU -> 0x80.
  - LH -> 0xFFFFFFFFFFFF8080.
  - LW -> 0xFFFFFFFF80008080.
  - LWU -> 0x80008080.
- Dual issue in one cycle: lane0 SW 0x40 data 0xDEADBEEF, lane1 LWU 0x40 rd=7.
  - Store issues first.
  - ld_data=0xDEADBEEF, rd=7, mem_store_format=10, mem_load_format=010.
- Backpressure, DEPTH=4: present dual requests every cycle for 6 cycles.
  - req_ready falls when count>2.
  - All ops execute exactly once in order; enables alternate high/low; busy clears after the last RELEASE.
- Lane1-only request: req1_valid=1, req0_valid=0, LD 0x10 rd=3 -> one entry enqueued, correct result with rd=3.

Source files
------------

// File: rtl/lsu_mem_queue.sv
// In-order load/store issue queue feeding the byte-addressed data memory.
// It accepts up to two ops per cycle and issues one access every two cycles, with an enable-low gap between accesses.
module lsu_mem_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    input  logic            req0_is_store,
    input  logic [2:0]      req0_funct3,
    input  logic [XLEN-1:0] req0_addr,
    input  logic [XLEN-1:0] req0_wdata,
    input  logic [4:0]      req0_rd,
    input  logic            req1_valid,
    input  logic            req1_is_store,
    input  logic [2:0]      req1_funct3,
    input  logic [XLEN-1:0] req1_addr,
    input  logic [XLEN-1:0] req1_wdata,
    input  logic [4:0]      req1_rd,
    output logic            req_ready,
    output logic [2:0]      mem_load_format,
    output logic [1:0]      mem_store_format,
    output logic            mem_write_en,
    output logic            mem_read_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data_input,
    input  logic [XLEN-1:0] mem_data_output,
    output logic            ld_valid,
    output logic [4:0]      ld_rd,
    output logic [XLEN-1:0] ld_data,
    output logic            busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t          state;
    logic            q_store [DEPTH];
    logic [2:0]      q_funct3 [DEPTH];
    logic [XLEN-1:0] q_addr [DEPTH];
    logic [XLEN-1:0] q_wdata [DEPTH];
    logic [4:0]      q_rd [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_idx1;
    logic [CW-1:0]   count, n_push;
    logic            push0, push1, pop;
    logic            cur_load;
    logic [2:0]      cur_funct3;
    logic [4:0]      cur_rd;

    function automatic logic [2:0] load_format(input logic [1:0] size);
        case (size)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            default: return 3'b101;
        endcase
    endfunction

    // Upper bytes from the memory are stale, so mask to the access size before extending.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic zx;
        zx = f3[2];
        case (f3[1:0])
            2'b00:   return {{(XLEN-8){~zx & d[7]}}, d[7:0]};
            2'b01:   return {{(XLEN-16){~zx & d[15]}}, d[15:0]};
            2'b10:   return {{(XLEN-32){~zx & d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    assign req_ready = (count <= CW'(DEPTH - 2));
    assign push0     = req_ready & req0_valid;
    assign push1     = req_ready & req1_valid;
    assign wr_idx1   = wr_ptr + PW'(push0);
    assign n_push    = CW'(push0) + CW'(push1);
    assign pop       = (state != ACCESS) && (count != '0);
    assign busy      = (count != '0) || (state != IDLE);

    // Lane0 is older, so it takes the first free slot; lane1 follows it (or takes it alone).
    always_ff @(posedge clk) begin
        if (push0) begin
            q_store[wr_ptr]  <= req0_is_store;
            q_funct3[wr_ptr] <= req0_funct3;
            q_addr[wr_ptr]   <= req0_addr;
            q_wdata[wr_ptr]  <= req0_wdata;
            q_rd[wr_ptr]     <= req0_rd;
        end
        if (push1) begin
            q_store[wr_idx1]  <= req1_is_store;
            q_funct3[wr_idx1] <= req1_funct3;
            q_addr[wr_idx1]   <= req1_addr;
            q_wdata[wr_idx1]  <= req1_wdata;
            q_rd[wr_idx1]     <= req1_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            mem_load_format  <= '0;
            mem_store_format <= '0;
            mem_write_en     <= 1'b0;
            mem_read_en      <= 1'b0;
            mem_addr         <= '0;
            mem_data_input   <= '0;
            ld_valid         <= 1'b0;
            ld_rd            <= '0;
            ld_data          <= '0;
            cur_load         <= 1'b0;
            cur_funct3       <= '0;
            cur_rd           <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(n_push);
            count    <= count + n_push - CW'(pop);
            ld_valid <= 1'b0;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case (state)
                IDLE, RELEASE: begin
                    mem_write_en <= 1'b0;
                    mem_read_en  <= 1'b0;
                    if (pop) begin
                        state            <= ACCESS;
                        mem_addr         <= q_addr[rd_ptr];
                        mem_data_input   <= q_wdata[rd_ptr];
                        mem_store_format <= q_funct3[rd_ptr][1:0];
                        mem_load_format  <= load_format(q_funct3[rd_ptr][1:0]);
                        mem_write_en     <= q_store[rd_ptr];
                        mem_read_en      <= ~q_store[rd_ptr];
                        cur_load         <= ~q_store[rd_ptr];
                        cur_funct3       <= q_funct3[rd_ptr];
                        cur_rd           <= q_rd[rd_ptr];
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    // Load data is valid from the memory during ACCESS; capture it at the closing edge.
                    state        <= RELEASE;
                    mem_write_en <= 1'b0;
                    mem_read_en  <= 1'b0;
                    if (cur_load) begin
                        ld_valid <= 1'b1;
                        ld_rd    <= cur_rd;
                        ld_data  <= extend_load(mem_data_output, cur_funct3);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_queue.sv
// Directed bench for lsu_mem_queue with a byte-array data memory model and an in-order access/load scoreboard.
module tb_lsu_mem_queue;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] exp;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ld_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req0_valid, req0_is_store, req1_valid, req1_is_store;
    logic [2:0]      req0_funct3, req1_funct3;
    logic [XLEN-1:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [4:0]      req0_rd, req1_rd;
    logic            req_ready;
    logic [2:0]      mem_load_format;
    logic [1:0]      mem_store_format;
    logic            mem_write_en, mem_read_en;
    logic [XLEN-1:0] mem_addr, mem_data_input, mem_data_output;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    int   issued = 0;
    int   started = 0;
    bit   prev_en = 1'b0;
    bit   saw_full = 1'b0;
    logic mem_init = 1'b0;
    op_t  exp_acc[$];
    ld_t  exp_ld[$];
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    lsu_mem_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_is_store(req0_is_store), .req0_funct3(req0_funct3),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rd(req0_rd),
        .req1_valid(req1_valid), .req1_is_store(req1_is_store), .req1_funct3(req1_funct3),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rd(req1_rd),
        .req_ready(req_ready), .mem_load_format(mem_load_format), .mem_store_format(mem_store_format),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
        .mem_data_input(mem_data_input), .mem_data_output(mem_data_output),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .busy(busy)
    );

    // Memory returns all 8 bytes at the address; bytes beyond the access size are stale.
    always_comb begin
        logic [7:0] a;
        a = '0;
        mem_data_output = '0;
        for (int i = 0; i < 8; i++) begin
            a = mem_addr[7:0] + 8'(i);
            mem_data_output[8*i +: 8] = mem[a];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (mem_write_en) begin
            for (int i = 0; i < 8; i++)
                if (i < (1 << mem_store_format)) mem[8'(mem_addr[7:0] + 8'(i))] <= mem_data_input[8*i +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] lfmt(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            default: return 3'b101;
        endcase
    endfunction

    function automatic op_t mk(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] exp);
        op_t o;
        o.st = st; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rd = rd; o.exp = exp;
        return o;
    endfunction

    // Scoreboard: every access must be the next expected op, never back-to-back enables.
    always @(negedge clk) begin : monitor
        logic en;
        op_t  o;
        ld_t  l;
        if (!reset_n) begin
            prev_en = 1'b0;
        end else begin
            en = mem_write_en | mem_read_en;
            if (en) begin
                check("en_gap", 64'(prev_en), 64'(0));
                check("en_both", 64'(mem_write_en & mem_read_en), 64'(0));
                if (exp_acc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL acc_unexpected: got access at %h expected none", mem_addr);
                end else begin
                    o = exp_acc.pop_front();
                    started++;
                    check("acc_store", 64'(mem_write_en), 64'(o.st));
                    check("acc_addr", mem_addr, o.addr);
                    if (o.st) begin
                        check("store_fmt", 64'(mem_store_format), 64'(o.f3[1:0]));
                        check("store_data", mem_data_input, o.wdata);
                    end else begin
                        check("load_fmt", 64'(mem_load_format), 64'(lfmt(o.f3)));
                    end
                end
            end
            prev_en = en;
            if (ld_valid) begin
                if (exp_ld.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ld_unexpected: got rd %0d data %h expected none", ld_rd, ld_data);
                end else begin
                    l = exp_ld.pop_front();
                    check("ld_rd", 64'(ld_rd), 64'(l.rd));
                    check("ld_data", ld_data, l.data);
                end
            end
        end
    end

    task automatic check_ready();
        int model_count;
        model_count = issued - started - int'(mem_write_en | mem_read_en);
        if (!req_ready) saw_full = 1'b1;
        check("req_ready", 64'(req_ready), 64'(model_count <= DEPTH - 2));
    endtask

    task automatic book(input op_t o);
        ld_t l;
        exp_acc.push_back(o);
        issued++;
        if (!o.st) begin
            l.rd = o.rd; l.data = o.exp;
            exp_ld.push_back(l);
        end
    endtask

    // Called and returns at posedge+1; holds requests while req_ready is low.
    task automatic issue(input op_t o0, input bit v0, input op_t o1, input bit v1);
        int n;
        n = 0;
        req0_valid = v0; req0_is_store = o0.st; req0_funct3 = o0.f3;
        req0_addr = o0.addr; req0_wdata = o0.wdata; req0_rd = o0.rd;
        req1_valid = v1; req1_is_store = o1.st; req1_funct3 = o1.f3;
        req1_addr = o1.addr; req1_wdata = o1.wdata; req1_rd = o1.rd;
        check_ready();
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            check_ready();
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready 0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk); #1;
            if (v0) book(o0);
            if (v1) book(o1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((busy || exp_acc.size() != 0 || exp_ld.size() != 0) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 64'(exp_acc.size() + exp_ld.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));
    endtask

    op_t table_ops[$];
    op_t none;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        none = mk(0, 3'b000, 64'h0, 64'h0, 5'd0, 64'h0);
        req0_valid = 0; req0_is_store = 0; req0_funct3 = 0; req0_addr = 0; req0_wdata = 0; req0_rd = 0;
        req1_valid = 0; req1_is_store = 0; req1_funct3 = 0; req1_addr = 0; req1_wdata = 0; req1_rd = 0;

        // Reset state
        reset_n = 1'b0;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst_we", 64'(mem_write_en), 64'(0));
        check("rst_re", 64'(mem_read_en), 64'(0));
        check("rst_addr", mem_addr, 64'h0);
        check("rst_ld_valid", 64'(ld_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: stores and loads issued back to back on lane0
        table_ops.push_back(mk(1, 3'b011, 64'h10, 64'h8877665544332211, 5'd0, 64'h0));
        table_ops.push_back(mk(0, 3'b011, 64'h10, 64'h0, 5'd5, 64'h8877665544332211));
        table_ops.push_back(mk(1, 3'b011, 64'h20, 64'h0000000080008080, 5'd0, 64'h0));
        table_ops.push_back(mk(0, 3'b000, 64'h20, 64'h0, 5'd1, 64'hFFFFFFFFFFFFFF80));
        table_ops.push_back(mk(0, 3'b100, 64'h20, 64'h0, 5'd2, 64'h0000000000000080));
        table_ops.push_back(mk(0, 3'b001, 64'h20, 64'h0, 5'd3, 64'hFFFFFFFFFFFF8080));
        table_ops.push_back(mk(0, 3'b010, 64'h20, 64'h0, 5'd4, 64'hFFFFFFFF80008080));
        table_ops.push_back(mk(0, 3'b110, 64'h20, 64'h0, 5'd6, 64'h0000000080008080));
        table_ops.push_back(mk(0, 3'b101, 64'h20, 64'h0, 5'd8, 64'h0000000000008080));
        table_ops.push_back(mk(1, 3'b000, 64'h30, 64'h123456789ABCDEF0, 5'd0, 64'h0));
        table_ops.push_back(mk(0, 3'b000, 64'h30, 64'h0, 5'd9, 64'hFFFFFFFFFFFFFFF0));
        table_ops.push_back(mk(1, 3'b001, 64'h38, 64'h0000000000007FFF, 5'd0, 64'h0));
        table_ops.push_back(mk(0, 3'b001, 64'h38, 64'h0, 5'd11, 64'h0000000000007FFF));
        table_ops.push_back(mk(0, 3'b111, 64'h10, 64'h0, 5'd12, 64'h8877665544332211));
        foreach (table_ops[i]) issue(table_ops[i], 1'b1, none, 1'b0);
        wait_idle(200);

        // Dual issue: lane0 store must reach memory before lane1 load
        issue(mk(1, 3'b010, 64'h40, 64'h00000000DEADBEEF, 5'd0, 64'h0), 1'b1,
              mk(0, 3'b110, 64'h40, 64'h0, 5'd7, 64'h00000000DEADBEEF), 1'b1);
        wait_idle(50);

        // Backpressure: six dual requests in a row
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [63:0] d, a;
            d = 64'(i + 1) * 64'h1111111111111111;
            a = 64'h80 + 64'(16 * i);
            issue(mk(1, 3'b011, a, d, 5'd0, 64'h0), 1'b1, mk(0, 3'b011, a, 64'h0, 5'(10 + i), d), 1'b1);
        end
        wait_idle(200);
        check("bp_saw_full", 64'(saw_full), 64'(1));

        // Lane1-only request with cycle-exact latency
        issue(none, 1'b0, mk(0, 3'b011, 64'h10, 64'h0, 5'd3, 64'h8877665544332211), 1'b1);
        check("lat_e1_busy", 64'(busy), 64'(1));
        check("lat_e1_re", 64'(mem_read_en), 64'(0));
        @(posedge clk); #1;
        check("lat_e2_re", 64'(mem_read_en), 64'(1));
        check("lat_e2_ldv", 64'(ld_valid), 64'(0));
        @(posedge clk); #1;
        check("lat_e3_re", 64'(mem_read_en), 64'(0));
        check("lat_e3_ldv", 64'(ld_valid), 64'(1));
        check("lat_e3_rd", 64'(ld_rd), 64'(3));
        check("lat_e3_data", ld_data, 64'h8877665544332211);
        @(posedge clk); #1;
        check("lat_e4_ldv", 64'(ld_valid), 64'(0));
        check("lat_e4_hold", ld_data, 64'h8877665544332211);
        check("lat_e4_busy", 64'(busy), 64'(0));

        // Reset in the middle of a load access
        issue(mk(0, 3'b011, 64'h10, 64'h0, 5'd9, 64'h8877665544332211), 1'b1, none, 1'b0);
        begin
            int n;
            n = 0;
            while (!mem_read_en && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check("mid_reach_access", 64'(mem_read_en), 64'(1));
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp_acc.delete();
        exp_ld.delete();
        issued = 0;
        started = 0;
        check("mid_rst_re", 64'(mem_read_en), 64'(0));
        check("mid_rst_we", 64'(mem_write_en), 64'(0));
        check("mid_rst_addr", mem_addr, 64'h0);
        check("mid_rst_fmt", 64'({mem_load_format, mem_store_format}), 64'(0));
        check("mid_rst_ld", 64'({ld_valid, ld_rd}), 64'(0));
        check("mid_rst_data", ld_data, 64'h0);
        check("mid_rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_ldv", 64'(ld_valid), 64'(0));
            check("post_rst_busy", 64'(busy), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
